// File: rtl/medfilt_pkg.sv
// rtl/medfilt_pkg.sv - shared FSM states, border bit positions and width helper
package medfilt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Bit positions inside win_border = {top, bottom, left, right}
  localparam int BRD_TOP    = 3;
  localparam int BRD_BOTTOM = 2;
  localparam int BRD_LEFT   = 1;
  localparam int BRD_RIGHT  = 0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((longint'(1) << i) < longint'(value)) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/medfilt_pos_cnt.sv
// rtl/medfilt_pos_cnt.sv - raster x/y position counter with enable, clear and load-zero
// load-zero treats the current cycle as position (0,0), so the counter then holds (1,0).
module medfilt_pos_cnt #(
  parameter int X_CNT = 640,
  parameter int Y_CNT = 512,
  parameter int XW    = 10,
  parameter int YW    = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic          i_clr,
  input  logic          i_load0,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y
);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          w_x_wrap;
  logic          w_y_wrap;

  assign w_x_wrap = (r_x == XW'(X_CNT - 1));
  assign w_y_wrap = (r_y == YW'(Y_CNT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_load0) begin
      r_x <= XW'(1);
      r_y <= '0;
    end else if (i_en) begin
      if (w_x_wrap) begin
        r_x <= '0;
        r_y <= w_y_wrap ? '0 : r_y + YW'(1);
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end

  assign o_x = r_x;
  assign o_y = r_y;

endmodule

// File: rtl/medfilt_win_ctrl.sv
// rtl/medfilt_win_ctrl.sv - pixel stream to line-buffer/window control for a 3x3 median filter
// Pixels pass straight to the line buffers; IMG_W+1 zero beats flush the last line through.
module medfilt_win_ctrl
  import medfilt_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 512
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_WIDTH-1:0]     s_data,
  input  logic                      s_sof,
  input  logic                      s_eol,
  output logic                      lb_en,
  output logic [DATA_WIDTH-1:0]     lb_data,
  output logic                      win_valid,
  output logic [clog2(IMG_W)-1:0]   win_x,
  output logic [clog2(IMG_H)-1:0]   win_y,
  output logic [3:0]                win_border,
  output logic                      frame_done,
  output logic                      err_eol,
  output logic                      err_sof
);

  localparam int XW = clog2(IMG_W);
  localparam int YW = clog2(IMG_H);
  localparam int KW = clog2(IMG_W * IMG_H + IMG_W + 2);
  localparam int FW = clog2(IMG_W + 1);
  localparam logic [KW-1:0] K_FIRST = KW'(IMG_W + 1);
  localparam logic [FW-1:0] FL_LAST = FW'(IMG_W);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [KW-1:0]   r_k;
  logic [KW-1:0]   w_k_cur;
  logic [FW-1:0]   r_fl;
  logic            w_start;
  logic            w_in_adv;
  logic            w_done;
  logic            w_eol_bad;
  logic            w_sof_bad;
  logic            w_fire;
  logic [XW-1:0]   w_in_x;
  logic [YW-1:0]   w_in_y;
  logic            w_in_xlast;
  logic            w_in_ylast;
  logic [XW-1:0]   w_c_x;
  logic [YW-1:0]   w_c_y;
  logic [3:0]      w_border;

  logic            r_win_valid;
  logic [XW-1:0]   r_win_x;
  logic [YW-1:0]   r_win_y;
  logic [3:0]      r_win_border;
  logic            r_frame_done;
  logic            r_err_eol;
  logic            r_err_sof;

  assign w_in_xlast = (w_in_x == XW'(IMG_W - 1));
  assign w_in_ylast = (w_in_y == YW'(IMG_H - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    s_ready     = 1'b1;
    lb_en       = 1'b0;
    lb_data     = '0;
    w_start     = 1'b0;
    w_in_adv    = 1'b0;
    w_done      = 1'b0;
    w_eol_bad   = 1'b0;
    w_sof_bad   = 1'b0;
    case (r_state)
      IDLE: begin
        if (s_valid && s_sof) begin
          lb_en       = 1'b1;
          lb_data     = s_data;
          w_start     = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (s_valid) begin
          lb_en   = 1'b1;
          lb_data = s_data;
          if (s_sof) begin
            // Restart: this beat is pixel (0,0), never a line end since IMG_W >= 4
            w_start   = 1'b1;
            w_sof_bad = 1'b1;
            w_eol_bad = s_eol;
          end else begin
            w_in_adv  = 1'b1;
            w_eol_bad = s_eol ^ w_in_xlast;
            if (w_in_xlast && w_in_ylast) w_state_nxt = FLUSH;
          end
        end
      end
      FLUSH: begin
        s_ready = 1'b0;
        lb_en   = 1'b1;
        if (r_fl == FL_LAST) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (!rst_n) begin
      s_ready   = 1'b1;
      lb_en     = 1'b0;
      w_start   = 1'b0;
      w_in_adv  = 1'b0;
      w_done    = 1'b0;
      w_eol_bad = 1'b0;
      w_sof_bad = 1'b0;
    end
  end

  // k of the current lb_en beat; a frame-start beat is always k = 0
  assign w_k_cur = w_start ? '0 : r_k;
  assign w_fire  = lb_en && (w_k_cur >= K_FIRST);

  medfilt_pos_cnt #(
    .X_CNT (IMG_W),
    .Y_CNT (IMG_H),
    .XW    (XW),
    .YW    (YW)
  ) u_in_pos (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_in_adv),
    .i_clr   (w_done),
    .i_load0 (w_start),
    .o_x     (w_in_x),
    .o_y     (w_in_y)
  );

  medfilt_pos_cnt #(
    .X_CNT (IMG_W),
    .Y_CNT (IMG_H),
    .XW    (XW),
    .YW    (YW)
  ) u_win_pos (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_fire),
    .i_clr   (w_start),
    .i_load0 (1'b0),
    .o_x     (w_c_x),
    .o_y     (w_c_y)
  );

  always_comb begin
    w_border             = '0;
    w_border[BRD_TOP]    = (w_c_y == '0);
    w_border[BRD_BOTTOM] = (w_c_y == YW'(IMG_H - 1));
    w_border[BRD_LEFT]   = (w_c_x == '0);
    w_border[BRD_RIGHT]  = (w_c_x == XW'(IMG_W - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_k          <= '0;
      r_fl         <= '0;
      r_win_valid  <= 1'b0;
      r_win_x      <= '0;
      r_win_y      <= '0;
      r_win_border <= '0;
      r_frame_done <= 1'b0;
      r_err_eol    <= 1'b0;
      r_err_sof    <= 1'b0;
    end else begin
      if (lb_en) r_k <= w_k_cur + KW'(1);
      r_fl         <= (r_state == FLUSH) ? r_fl + FW'(1) : '0;
      r_win_valid  <= w_fire;
      r_win_x      <= w_fire ? w_c_x : '0;
      r_win_y      <= w_fire ? w_c_y : '0;
      r_win_border <= w_fire ? w_border : '0;
      r_frame_done <= w_done;
      r_err_eol    <= w_eol_bad;
      r_err_sof    <= w_sof_bad;
    end
  end

  assign win_valid  = r_win_valid;
  assign win_x      = r_win_x;
  assign win_y      = r_win_y;
  assign win_border = r_win_border;
  assign frame_done = r_frame_done;
  assign err_eol    = r_err_eol;
  assign err_sof    = r_err_sof;

endmodule

// File: tb/tb_medfilt_win_ctrl.sv
// tb/tb_medfilt_win_ctrl.sv - randomized bench for medfilt_win_ctrl against a frame-level model
module tb_medfilt_win_ctrl;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_sof = 1'b0;
  logic          s_eol = 1'b0;
  logic          lb_en;
  logic [DW-1:0] lb_data;
  logic          win_valid;
  logic [2:0]    win_x;
  logic [1:0]    win_y;
  logic [3:0]    win_border;
  logic          frame_done;
  logic          err_eol;
  logic          err_sof;

  always #5 clk = ~clk;

  medfilt_win_ctrl #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_sof      (s_sof),
    .s_eol      (s_eol),
    .lb_en      (lb_en),
    .lb_data    (lb_data),
    .win_valid  (win_valid),
    .win_x      (win_x),
    .win_y      (win_y),
    .win_border (win_border),
    .frame_done (frame_done),
    .err_eol    (err_eol),
    .err_sof    (err_sof)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Stimulus beats
  logic [DW-1:0] b_data[$];
  bit            b_sof[$];
  bit            b_eol[$];

  task automatic clear_beats();
    b_data.delete(); b_sof.delete(); b_eol.delete();
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input bit sof, input bit eol);
    b_data.push_back(d); b_sof.push_back(sof); b_eol.push_back(eol);
  endtask

  task automatic push_pixels(input int n);
    for (int p = 0; p < n; p++)
      push_beat(DW'($urandom), p == 0, (p % W) == W - 1);
  endtask

  // Reference model: expected streams derived from frame rules
  logic [DW-1:0] exp_lb[$];
  int            exp_win[$];
  int            exp_done, exp_eol, exp_sof;

  function automatic int win_code(input int x, input int y);
    int b;
    b = ((y == 0) ? 8 : 0) + ((y == H - 1) ? 4 : 0) + ((x == 0) ? 2 : 0) + ((x == W - 1) ? 1 : 0);
    return (x << 8) | (y << 4) | b;
  endfunction

  task automatic emit_windows(input int n_lb);
    for (int j = 0; j < n_lb - (W + 1); j++) exp_win.push_back(win_code(j % W, j / W));
  endtask

  task automatic build_model();
    int pos;
    bit in_frame;
    exp_lb.delete(); exp_win.delete();
    exp_done = 0; exp_eol = 0; exp_sof = 0;
    pos = 0; in_frame = 0;
    foreach (b_data[i]) begin
      if (b_sof[i]) begin
        if (in_frame) begin
          exp_sof++;
          emit_windows(pos);
          if (b_eol[i]) exp_eol++;
        end
        in_frame = 1; pos = 0;
      end else if (!in_frame) begin
        continue;
      end else if (b_eol[i] != ((pos % W) == W - 1)) begin
        exp_eol++;
      end
      exp_lb.push_back(b_data[i]);
      pos++;
      if (pos == W * H) begin
        repeat (W + 1) exp_lb.push_back('0);
        emit_windows(pos + W + 1);
        exp_done++;
        in_frame = 0;
      end
    end
  endtask

  // Monitor
  int            cyc = 0;
  logic [DW-1:0] m_lb[$];
  int            m_lb_cyc[$];
  int            m_win[$];
  int            m_win_cyc[$];
  int            m_done, m_done_cyc, m_eol, m_sof, m_gap_bad, m_path_bad, m_brd_bad;

  task automatic mon_clear();
    m_lb.delete(); m_lb_cyc.delete(); m_win.delete(); m_win_cyc.delete();
    m_done = 0; m_done_cyc = -1; m_eol = 0; m_sof = 0;
    m_gap_bad = 0; m_path_bad = 0; m_brd_bad = 0;
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (lb_en) begin
      m_lb.push_back(lb_data);
      m_lb_cyc.push_back(cyc);
      if (s_ready) begin
        if (!s_valid || lb_data !== s_data) m_path_bad++;
      end else if (lb_data !== '0) begin
        m_path_bad++;
      end
    end
    if (!s_valid && s_ready && lb_en) m_gap_bad++;
    if (win_valid) begin
      m_win.push_back((int'(win_x) << 8) | (int'(win_y) << 4) | int'(win_border));
      m_win_cyc.push_back(cyc);
    end else if (win_border !== 4'b0) begin
      m_brd_bad++;
    end
    if (frame_done) begin m_done++; m_done_cyc = cyc; end
    if (err_eol) m_eol++;
    if (err_sof) m_sof++;
  end

  task automatic run_beats(input int gap_pct);
    foreach (b_data[i]) begin
      int guard;
      bit acc;
      while ($urandom_range(99) < gap_pct) begin
        s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b1; s_data = b_data[i]; s_sof = b_sof[i]; s_eol = b_eol[i];
      guard = 0;
      forever begin
        @(negedge clk); acc = s_ready;
        @(posedge clk); #1;
        if (acc) break;
        guard++;
        if (guard > 50) begin check("ready_timeout", 0, 1); break; end
      end
    end
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic compare(input string sc);
    check({sc, "/lb_count"}, m_lb.size(), exp_lb.size());
    for (int i = 0; i < m_lb.size() && i < exp_lb.size(); i++)
      check($sformatf("%s/lb_data[%0d]", sc, i), m_lb[i], exp_lb[i]);
    check({sc, "/win_count"}, m_win.size(), exp_win.size());
    for (int i = 0; i < m_win.size() && i < exp_win.size(); i++)
      check($sformatf("%s/win[%0d]", sc, i), m_win[i], exp_win[i]);
    check({sc, "/frame_done"}, m_done, exp_done);
    check({sc, "/err_eol"}, m_eol, exp_eol);
    check({sc, "/err_sof"}, m_sof, exp_sof);
    check({sc, "/lb_in_gap"}, m_gap_bad, 0);
    check({sc, "/lb_path"}, m_path_bad, 0);
    check({sc, "/border_idle"}, m_brd_bad, 0);
  endtask

  task automatic check_timing(input string sc);
    int bad;
    bad = 0;
    if (m_lb_cyc.size() == W * H + W + 1 && m_win_cyc.size() == W * H) begin
      check({sc, "/first_win_after_lb10"}, m_win_cyc[0], m_lb_cyc[W + 1] + 1);
      for (int j = 0; j < W * H; j++)
        if (m_win_cyc[j] != m_lb_cyc[j + W + 1] + 1) bad++;
      check({sc, "/win_latency"}, bad, 0);
      check({sc, "/done_cycle"}, m_done_cyc, m_lb_cyc[W * H + W] + 1);
    end else begin
      check({sc, "/timing_lb_count"}, m_lb_cyc.size(), W * H + W + 1);
      check({sc, "/timing_win_count"}, m_win_cyc.size(), W * H);
    end
  endtask

  task automatic scenario(input string sc, input int gap_pct, input bit timing);
    build_model();
    mon_clear();
    run_beats(gap_pct);
    idle(20);
    compare(sc);
    if (timing) check_timing(sc);
  endtask

  initial begin
    mon_clear();
    idle(2);
    @(negedge clk);
    check("rst/s_ready", s_ready, 1);
    check("rst/lb_en", lb_en, 0);
    check("rst/win_valid", win_valid, 0);
    check("rst/win_xy", {win_x, win_y}, 0);
    check("rst/win_border", win_border, 0);
    check("rst/pulses", {frame_done, err_eol, err_sof}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    clear_beats(); push_pixels(W * H);
    scenario("clean", 0, 1);

    clear_beats(); push_pixels(W * H);
    scenario("gaps", 50, 1);

    clear_beats();
    for (int i = 0; i < 5; i++) push_beat(DW'($urandom), 0, 0);
    push_pixels(W * H);
    scenario("no_sof", 30, 1);

    clear_beats(); push_pixels(W * H);
    b_eol[W + 5] = 1'b1;
    scenario("bad_eol", 20, 1);

    clear_beats(); push_pixels(20); push_pixels(W * H);
    scenario("resof", 20, 0);

    clear_beats(); push_pixels(W * H);
    mon_clear();
    run_beats(0);
    idle(3);
    rst_n = 1'b0;
    @(negedge clk);
    check("flush_rst/s_ready", s_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("flush_rst/lb_en", lb_en, 0);
    check("flush_rst/s_ready_idle", s_ready, 1);
    check("flush_rst/win_valid", win_valid, 0);
    check("flush_rst/win_border", win_border, 0);
    check("flush_rst/frame_done", frame_done, 0);
    idle(15);
    check("flush_rst/no_done", m_done, 0);
    clear_beats(); push_pixels(W * H);
    scenario("after_rst", 40, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
